// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle multiply/divide unit owning the HI/LO registers
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   in1     forwarded rs operand
//   in2     forwarded rt operand
//   MDUcon  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//           5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none
//   start   E-stage instruction valid, qualifies MDUcon
//   busy    multiply/divide in flight
//   HI, LO  architectural HI/LO registers
//   MDUout  mfhi/mflo read data, zero otherwise
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [3:0]  MDUcon,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUout
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_state, w_state_nx;
    logic [CW-1:0]  r_cnt, w_cnt_nx;
    logic [31:0]    r_a, w_a_nx;
    logic [31:0]    r_b, w_b_nx;
    logic [3:0]     r_op, w_op_nx;
    logic [31:0]    r_hi, w_hi_nx;
    logic [31:0]    r_lo, w_lo_nx;

    logic [63:0]    w_prod_s;
    logic [63:0]    w_prod_u;
    logic           w_div_zero;
    logic           w_div_ovf;
    logic [31:0]    w_dvsr;
    logic [31:0]    w_quo_s, w_rem_s;
    logic [31:0]    w_quo_u, w_rem_u;

    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // The divider never sees 0 or the INT_MIN/-1 pair: substituting 1 for the
    // overflow case yields exactly LO=0x80000000, HI=0, and a zero divisor
    // suppresses the write so its substitute value is irrelevant.
    assign w_div_zero = (r_b == 32'd0);
    assign w_div_ovf  = (r_op == OP_DIV) && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
    assign w_dvsr     = (w_div_zero || w_div_ovf) ? 32'd1 : r_b;
    assign w_quo_s    = $signed(r_a) / $signed(w_dvsr);
    assign w_rem_s    = $signed(r_a) % $signed(w_dvsr);
    assign w_quo_u    = r_a / w_dvsr;
    assign w_rem_u    = r_a % w_dvsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= OP_NONE;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_op    <= w_op_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_op_nx    = r_op;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (MDUcon)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            w_a_nx     = in1;
                            w_b_nx     = in2;
                            w_op_nx    = MDUcon;
                            w_cnt_nx   = ((MDUcon == OP_MULT) || (MDUcon == OP_MULTU))
                                         ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                            w_state_nx = S_RUN;
                        end
                        OP_MTHI: w_hi_nx = in1;
                        OP_MTLO: w_lo_nx = in1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // start is deliberately ignored here; the countdown alone runs.
                w_cnt_nx = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_state_nx = S_IDLE;
                    w_op_nx    = OP_NONE;
                    case (r_op)
                        OP_MULT: begin
                            w_hi_nx = w_prod_s[63:32];
                            w_lo_nx = w_prod_s[31:0];
                        end
                        OP_MULTU: begin
                            w_hi_nx = w_prod_u[63:32];
                            w_lo_nx = w_prod_u[31:0];
                        end
                        OP_DIV: begin
                            if (!w_div_zero) begin
                                w_hi_nx = w_rem_s;
                                w_lo_nx = w_quo_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!w_div_zero) begin
                                w_hi_nx = w_rem_u;
                                w_lo_nx = w_quo_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

    // Reads see the current registers even mid-operation; stalling is external.
    always_comb begin
        MDUout = 32'd0;
        if (start && (MDUcon == OP_MFHI)) MDUout = r_hi;
        if (start && (MDUcon == OP_MFLO)) MDUout = r_lo;
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking bench for e_mdu
module tb_e_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in1, in2;
    logic [3:0]  MDUcon;
    logic        start;
    logic        busy;
    logic [31:0] HI, LO, MDUout;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .in1(in1), .in2(in2), .MDUcon(MDUcon),
        .start(start), .busy(busy), .HI(HI), .LO(LO), .MDUout(MDUout)
    );

    always #5 clk = ~clk;

    // Architectural reference: updates m_hi/m_lo, returns expected busy length.
    function automatic int model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; return MULT_N; end
            4'd2: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; return MULT_N; end
            4'd3: begin
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    p = q; m_lo = p[31:0];
                    p = r; m_hi = p[31:0];
                end
                return DIV_N;
            end
            4'd4: begin
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
                return DIV_N;
            end
            4'd7: begin m_hi = a; return 0; end
            4'd8: begin m_lo = a; return 0; end
            default: return 0;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int exp_cyc, cyc;
        exp_cyc = model_apply(op, a, b);
        @(negedge clk);
        in1 = a; in2 = b; MDUcon = op; start = 1'b1;
        #1;
        n_cmp++;
        if (MDUout !== 32'd0) begin
            n_fail++;
            $display("FAIL %s mdu_out_nonread got=%h want=%h", name, MDUout, 32'd0);
        end
        @(negedge clk);
        start = 1'b0; MDUcon = 4'd0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL %s busy_cycles got=%0d want=%0d", name, cyc, exp_cyc);
        end
        n_cmp++;
        if (HI !== m_hi) begin
            n_fail++;
            $display("FAIL %s hi got=%h want=%h", name, HI, m_hi);
        end
        n_cmp++;
        if (LO !== m_lo) begin
            n_fail++;
            $display("FAIL %s lo got=%h want=%h", name, LO, m_lo);
        end
    endtask

    task automatic read_check(input string name);
        @(negedge clk);
        MDUcon = 4'd5; start = 1'b1;
        #1;
        n_cmp++;
        if (MDUout !== m_hi) begin
            n_fail++;
            $display("FAIL %s mfhi got=%h want=%h", name, MDUout, m_hi);
        end
        MDUcon = 4'd6;
        #1;
        n_cmp++;
        if (MDUout !== m_lo) begin
            n_fail++;
            $display("FAIL %s mflo got=%h want=%h", name, MDUout, m_lo);
        end
        start = 1'b0;
        #1;
        n_cmp++;
        if (MDUout !== 32'd0) begin
            n_fail++;
            $display("FAIL %s mflo_nostart got=%h want=%h", name, MDUout, 32'd0);
        end
        MDUcon = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in1 = '0; in2 = '0; MDUcon = '0; start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_op("pre_reset_mthi", 4'd7, 32'hDEAD_BEEF, 32'd0);
        run_op("pre_reset_mtlo", 4'd8, 32'h0BAD_F00D, 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        n_cmp++;
        if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async got=%h/%h/%b want=0/0/0", HI, LO, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        read_check("after_reset");
    endtask

    task automatic test_mult();
        run_op("mult_neg2x3", 4'd1, 32'hFFFF_FFFE, 32'd3);
        n_cmp++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
            n_fail++;
            $display("FAIL mult_const got=%h_%h want=ffffffff_fffffffa", HI, LO);
        end
    endtask

    task automatic test_multu_div();
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2);
        run_op("div_neg7_2", 4'd3, 32'hFFFF_FFF9, 32'd2);
        n_cmp++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_const got=%h_%h want=ffffffff_fffffffd", HI, LO);
        end
        run_op("divu", 4'd4, 32'hFFFF_FFF9, 32'd2);
        read_check("after_divu");
    endtask

    task automatic test_div_corner();
        run_op("mthi", 4'd7, 32'h1234, 32'd0);
        run_op("mtlo", 4'd8, 32'h5678, 32'd0);
        run_op("div_by_zero", 4'd3, 32'd55, 32'd0);
        run_op("divu_by_zero", 4'd4, 32'd55, 32'd0);
        run_op("div_overflow", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_ovf_const got=%h_%h want=00000000_80000000", HI, LO);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] old_hi;
        int cyc;
        old_hi = m_hi;
        void'(model_apply(4'd1, 32'd3, 32'd4));
        @(negedge clk);
        in1 = 32'd3; in2 = 32'd4; MDUcon = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUcon = 4'd0;
        cyc = 1;
        @(negedge clk);
        cyc++;
        in1 = 32'hAAAA; MDUcon = 4'd7; start = 1'b1;
        @(negedge clk);
        cyc++;
        MDUcon = 4'd5;
        #1;
        n_cmp++;
        if (MDUout !== old_hi) begin
            n_fail++;
            $display("FAIL busy_mfhi got=%h want=%h", MDUout, old_hi);
        end
        start = 1'b0; MDUcon = 4'd0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (cyc != MULT_N) begin
            n_fail++;
            $display("FAIL busy_ignore_cycles got=%0d want=%0d", cyc, MULT_N);
        end
        n_cmp++;
        if (HI !== 32'd0 || LO !== 32'd12 || HI !== m_hi || LO !== m_lo) begin
            n_fail++;
            $display("FAIL busy_ignore_result got=%h_%h want=00000000_0000000c", HI, LO);
        end
    endtask

    task automatic test_reset_midop();
        int bad;
        @(negedge clk);
        in1 = 32'd100; in2 = 32'd7; MDUcon = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUcon = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        n_cmp++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_midop got=%b/%h/%h want=0/0/0", busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_no_late_write bad_cycles=%0d want=0", bad);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ops [10];
        logic [3:0]  op;
        logic [31:0] a, b;
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd0, 4'd9, 4'd12, 4'd15};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(9, 0)];
            a  = $urandom;
            case ($urandom_range(7, 0))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(9, 1);
                default: b = $urandom;
            endcase
            if ($urandom_range(7, 0) == 0) a = 32'h8000_0000;
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b);
            if (i % 4 == 0) read_check($sformatf("rand%0d_read", i));
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_div();
        test_div_corner();
        test_busy_ignore();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
